// File: rtl/alarm_ctrl_pkg.sv
// Shared encodings and constants for the alarm scheduler.
package alarm_ctrl_pkg;

  // Ring sequencing states
  typedef enum logic [1:0] {
    RingWait,
    RingRing,
    RingSnooze
  } ring_st_e;

  // Alarm-time setting states
  typedef enum logic [1:0] {
    SetNormal,
    SetHour,
    SetMin
  } set_st_e;

  // BCD wrap limits (23 and 59)
  localparam int unsigned HourMaxTens  = 2;
  localparam int unsigned HourMaxUnits = 3;
  localparam int unsigned MinMaxTens   = 5;
  localparam int unsigned MinMaxUnits  = 9;

  // Alarm time after reset: 06:00
  localparam logic [1:0] RstAHourH = 2'd0;
  localparam logic [3:0] RstAHourL = 4'd6;
  localparam logic [2:0] RstAMinH  = 3'd0;
  localparam logic [3:0] RstAMinL  = 4'd0;

endpackage

// File: rtl/alm_bcd_inc.sv
// Two-digit BCD increment that wraps to 00 after LIMIT_TENS:LIMIT_UNITS.
module alm_bcd_inc #(
  parameter int unsigned TW          = 3,
  parameter int unsigned LIMIT_TENS  = 5,
  parameter int unsigned LIMIT_UNITS = 9
) (
  input  logic [TW-1:0] tens,
  input  logic [3:0]    units,
  output logic [TW-1:0] tens_nxt,
  output logic [3:0]    units_nxt
);

  // Wrap at the limit, carry from units into tens at 9
  always_comb begin
    tens_nxt  = tens;
    units_nxt = units;
    if (tens == TW'(LIMIT_TENS) && units == 4'(LIMIT_UNITS)) begin
      tens_nxt  = '0;
      units_nxt = 4'd0;
    end else if (units == 4'd9) begin
      tens_nxt  = tens + TW'(1);
      units_nxt = 4'd0;
    end else begin
      units_nxt = units + 4'd1;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm scheduler: alarm-time setting, match trigger, ring/snooze/stop sequencing.
// Optional build macro ALM_SNOOZE_LIMIT_EN caps snoozes at MAX_SNOOZE per ring episode.
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN1HZ,
  input  logic       SIG2HZ,
  input  logic [1:0] HOURH,
  input  logic [3:0] HOURL,
  input  logic [2:0] MINH,
  input  logic [3:0] MINL,
  input  logic [2:0] SECH,
  input  logic [3:0] SECL,
  input  logic       SET,
  input  logic       ADJ,
  input  logic       SNZ,
  input  logic       ONOFF,
  output logic [1:0] AHOURH,
  output logic [3:0] AHOURL,
  output logic [2:0] AMINH,
  output logic [3:0] AMINL,
  output logic       AHOURON,
  output logic       AMINON,
  output logic       ALMEN,
  output logic       SETTING,
  output logic       RINGING,
  output logic       BEEP
);

  localparam logic [8:0] RingLoad   = 9'(RING_SEC);
  localparam logic [8:0] SnoozeLoad = 9'(SNOOZE_SEC);

  ring_st_e   ring_q;
  set_st_e    set_q;
  logic       almen_q;
  logic       match_q;
  logic       beep_q;
  logic [8:0] cnt_q;
  logic [1:0] ahh_q;
  logic [3:0] ahl_q;
  logic [2:0] amh_q;
  logic [3:0] aml_q;

  logic [1:0] hour_h_nxt;
  logic [3:0] hour_l_nxt;
  logic [2:0] min_h_nxt;
  logic [3:0] min_l_nxt;
  logic       match;
  logic       trig;

`ifdef ALM_SNOOZE_LIMIT_EN
  localparam logic [7:0] SnzMax = 8'(MAX_SNOOZE);
  logic [7:0] snz_cnt_q;
`else
  logic [31:0] unused_max_snooze;
  assign unused_max_snooze = MAX_SNOOZE;
`endif

  alm_bcd_inc #(
    .TW          (2),
    .LIMIT_TENS  (HourMaxTens),
    .LIMIT_UNITS (HourMaxUnits)
  ) u_hour_inc (
    .tens      (ahh_q),
    .units     (ahl_q),
    .tens_nxt  (hour_h_nxt),
    .units_nxt (hour_l_nxt)
  );

  alm_bcd_inc #(
    .TW          (3),
    .LIMIT_TENS  (MinMaxTens),
    .LIMIT_UNITS (MinMaxUnits)
  ) u_min_inc (
    .tens      (amh_q),
    .units     (aml_q),
    .tens_nxt  (min_h_nxt),
    .units_nxt (min_l_nxt)
  );

  assign match = ({HOURH, HOURL} == {ahh_q, ahl_q}) && ({MINH, MINL} == {amh_q, aml_q}) &&
                 (SECH == 3'd0) && (SECL == 4'd0);
  assign trig  = match & ~match_q & almen_q & (set_q == SetNormal);

  // Setting FSM and alarm-time registers; buttons belong to the ring FSM while it is active
  always_ff @(posedge CLK) begin
    if (RST) begin
      set_q <= SetNormal;
      ahh_q <= RstAHourH;
      ahl_q <= RstAHourL;
      amh_q <= RstAMinH;
      aml_q <= RstAMinL;
    end else if (ring_q == RingWait) begin
      unique case (set_q)
        SetNormal: if (SET) set_q <= SetHour;
        SetHour: begin
          if (SET) begin
            set_q <= SetMin;
          end else if (ADJ) begin
            ahh_q <= hour_h_nxt;
            ahl_q <= hour_l_nxt;
          end
        end
        SetMin: begin
          if (SET) begin
            set_q <= SetNormal;
          end else if (ADJ) begin
            amh_q <= min_h_nxt;
            aml_q <= min_l_nxt;
          end
        end
        default: set_q <= SetNormal;
      endcase
    end
  end

  // Alarm enable toggle and match edge history
  always_ff @(posedge CLK) begin
    if (RST) begin
      almen_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      if (ONOFF) almen_q <= ~almen_q;
      match_q <= match;
    end
  end

  // Ring FSM: disable > stop > snooze > counter expiry
  always_ff @(posedge CLK) begin
    if (RST) begin
      ring_q    <= RingWait;
      cnt_q     <= '0;
`ifdef ALM_SNOOZE_LIMIT_EN
      snz_cnt_q <= '0;
`endif
    end else if (ONOFF && almen_q) begin
      ring_q <= RingWait;
      cnt_q  <= '0;
    end else begin
      unique case (ring_q)
        RingWait: begin
`ifdef ALM_SNOOZE_LIMIT_EN
          snz_cnt_q <= '0;
`endif
          if (trig) begin
            ring_q <= RingRing;
            cnt_q  <= RingLoad;
          end
        end
        RingRing: begin
          if (ADJ || SET) begin
            ring_q <= RingWait;
            cnt_q  <= '0;
          end else if (SNZ) begin
`ifdef ALM_SNOOZE_LIMIT_EN
            if (snz_cnt_q == SnzMax) begin
              ring_q <= RingWait;
              cnt_q  <= '0;
            end else begin
              ring_q    <= RingSnooze;
              cnt_q     <= SnoozeLoad;
              snz_cnt_q <= snz_cnt_q + 8'd1;
            end
`else
            ring_q <= RingSnooze;
            cnt_q  <= SnoozeLoad;
`endif
          end else if (EN1HZ) begin
            if (cnt_q <= 9'd1) begin
              ring_q <= RingWait;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q - 9'd1;
            end
          end
        end
        RingSnooze: begin
          if (ADJ || SET) begin
            ring_q <= RingWait;
            cnt_q  <= '0;
          end else if (EN1HZ) begin
            if (cnt_q <= 9'd1) begin
              ring_q <= RingRing;
              cnt_q  <= RingLoad;
            end else begin
              cnt_q <= cnt_q - 9'd1;
            end
          end
        end
        default: begin
          ring_q <= RingWait;
          cnt_q  <= '0;
        end
      endcase
    end
  end

  // Beeper gated by the 2 Hz wave while ringing
  always_ff @(posedge CLK) begin
    if (RST) beep_q <= 1'b0;
    else     beep_q <= (ring_q == RingRing) & SIG2HZ;
  end

  assign AHOURH  = ahh_q;
  assign AHOURL  = ahl_q;
  assign AMINH   = amh_q;
  assign AMINL   = aml_q;
  assign AHOURON = (set_q == SetHour) ? SIG2HZ : 1'b1;
  assign AMINON  = (set_q == SetMin) ? SIG2HZ : 1'b1;
  assign ALMEN   = almen_q;
  assign SETTING = (set_q != SetNormal);
  assign RINGING = (ring_q == RingRing);
  assign BEEP    = beep_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed-vector bench for alarm_ctrl (default RING_SEC=60, SNOOZE_SEC=300, MAX_SNOOZE=3).
module tb_alarm_ctrl;

  logic       CLK = 1'b0;
  logic       RST, EN1HZ, SIG2HZ, SET, ADJ, SNZ, ONOFF;
  logic [1:0] HOURH;
  logic [3:0] HOURL, MINL, SECL;
  logic [2:0] MINH, SECH;
  logic [1:0] AHOURH;
  logic [3:0] AHOURL, AMINL;
  logic [2:0] AMINH;
  logic       AHOURON, AMINON, ALMEN, SETTING, RINGING, BEEP;

  int vectors = 0;
  int miscompares = 0;

  alarm_ctrl u_dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN1HZ   (EN1HZ),
    .SIG2HZ  (SIG2HZ),
    .HOURH   (HOURH),
    .HOURL   (HOURL),
    .MINH    (MINH),
    .MINL    (MINL),
    .SECH    (SECH),
    .SECL    (SECL),
    .SET     (SET),
    .ADJ     (ADJ),
    .SNZ     (SNZ),
    .ONOFF   (ONOFF),
    .AHOURH  (AHOURH),
    .AHOURL  (AHOURL),
    .AMINH   (AMINH),
    .AMINL   (AMINL),
    .AHOURON (AHOURON),
    .AMINON  (AMINON),
    .ALMEN   (ALMEN),
    .SETTING (SETTING),
    .RINGING (RINGING),
    .BEEP    (BEEP)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input int which);
    case (which)
      0: SET = 1'b1;
      1: ADJ = 1'b1;
      2: SNZ = 1'b1;
      default: ONOFF = 1'b1;
    endcase
    tick();
    SET = 1'b0; ADJ = 1'b0; SNZ = 1'b0; ONOFF = 1'b0;
  endtask

  task automatic secs(input int n);
    for (int i = 0; i < n; i++) begin
      EN1HZ = 1'b1;
      tick();
      EN1HZ = 1'b0;
    end
  endtask

  // Live time given as packed BCD hh/mm/ss bytes
  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    HOURH = h[5:4]; HOURL = h[3:0];
    MINH  = m[6:4]; MINL  = m[3:0];
    SECH  = s[6:4]; SECL  = s[3:0];
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, " ahour"}, {AHOURH, AHOURL}, 32'h06);
    check_eq({tag, " amin"}, {AMINH, AMINL}, 32'h00);
    check_eq({tag, " almen"}, ALMEN, 0);
    check_eq({tag, " setting"}, SETTING, 0);
    check_eq({tag, " ringing"}, RINGING, 0);
    check_eq({tag, " beep"}, BEEP, 0);
    check_eq({tag, " ahouron"}, AHOURON, 1);
    check_eq({tag, " aminon"}, AMINON, 1);
  endtask

  initial begin
    RST = 1'b1; EN1HZ = 1'b0; SIG2HZ = 1'b1;
    SET = 1'b0; ADJ = 1'b0; SNZ = 1'b0; ONOFF = 1'b0;
    set_time(8'h12, 8'h34, 8'h56);
    tick(); tick();
    RST = 1'b0;
    tick();
    check_reset_state("reset");

    // Set alarm to 09:02
    press(0);
    check_eq("set hour mode", SETTING, 1);
    SIG2HZ = 1'b0; #1;
    check_eq("hour blink low", AHOURON, 0);
    check_eq("min steady", AMINON, 1);
    SIG2HZ = 1'b1; #1;
    check_eq("hour blink high", AHOURON, 1);
    for (int i = 0; i < 3; i++) press(1);
    press(0);
    for (int i = 0; i < 2; i++) press(1);
    press(0);
    check_eq("alarm hour 09", {AHOURH, AHOURL}, 32'h09);
    check_eq("alarm min 02", {AMINH, AMINL}, 32'h02);
    check_eq("setting done", SETTING, 0);

    // Arm and trigger at 09:02:00
    press(3);
    check_eq("armed", ALMEN, 1);
    set_time(8'h09, 8'h01, 8'h59);
    tick();
    check_eq("no ring 09:01:59", RINGING, 0);
    set_time(8'h09, 8'h02, 8'h00);
    tick();
    check_eq("ring on match", RINGING, 1);
    check_eq("beep latency", BEEP, 0);
    tick();
    check_eq("beep high", BEEP, 1);
    SIG2HZ = 1'b0;
    tick();
    check_eq("beep gated", BEEP, 0);
    SIG2HZ = 1'b1;
    secs(59);
    check_eq("ring at 59 s", RINGING, 1);
    secs(1);
    check_eq("auto stop at 60 s", RINGING, 0);
    tick(); tick();
    check_eq("no retrigger same second", RINGING, 0);

    // Snooze then stop
    set_time(8'h09, 8'h01, 8'h59); tick();
    set_time(8'h09, 8'h02, 8'h00); tick();
    check_eq("ring again", RINGING, 1);
    press(2);
    check_eq("snoozing", RINGING, 0);
    secs(299);
    check_eq("snooze at 299 s", RINGING, 0);
    secs(1);
    check_eq("re-ring after snooze", RINGING, 1);
    press(1);
    check_eq("adj stops", RINGING, 0);
    check_eq("adj leaves hour", {AHOURH, AHOURL}, 32'h09);
    check_eq("adj leaves min", {AMINH, AMINL}, 32'h02);
    tick(); tick();
    check_eq("no retrigger after stop", RINGING, 0);

    // SET during ring stops and is consumed
    set_time(8'h09, 8'h01, 8'h59); tick();
    set_time(8'h09, 8'h02, 8'h00); tick();
    check_eq("ring for set-stop", RINGING, 1);
    press(0);
    check_eq("set stops", RINGING, 0);
    check_eq("set consumed", SETTING, 0);

    // Wrap: 23:59 then hour -> 00:59, minute -> 00:00
    press(0);
    for (int i = 0; i < 14; i++) press(1);
    press(0);
    for (int i = 0; i < 57; i++) press(1);
    press(0);
    check_eq("alarm 23", {AHOURH, AHOURL}, 32'h23);
    check_eq("alarm 59", {AMINH, AMINL}, 32'h59);
    press(0);
    press(1);
    check_eq("hour wraps", {AHOURH, AHOURL}, 32'h00);
    check_eq("min kept", {AMINH, AMINL}, 32'h59);
    press(0);
    set_time(8'h00, 8'h00, 8'h00);
    tick(); tick();
    press(1);
    check_eq("min wraps", {AMINH, AMINL}, 32'h00);
    check_eq("hour no carry", {AHOURH, AHOURL}, 32'h00);
    tick();
    press(0);
    tick(); tick();
    check_eq("no trig from edit", RINGING, 0);

    // ONOFF and SNZ together while ringing
    set_time(8'h23, 8'h59, 8'h59); tick();
    set_time(8'h00, 8'h00, 8'h00); tick();
    check_eq("ring 00:00", RINGING, 1);
    tick();
    check_eq("beep before off", BEEP, 1);
    SIG2HZ = 1'b0; ONOFF = 1'b1; SNZ = 1'b1;
    tick();
    ONOFF = 1'b0; SNZ = 1'b0; SIG2HZ = 1'b1;
    check_eq("off disarms", ALMEN, 0);
    check_eq("off stops ring", RINGING, 0);
    check_eq("off beep", BEEP, 0);
    tick();
    check_eq("off beep later", BEEP, 0);

    // Reset during snooze
    press(3);
    set_time(8'h23, 8'h59, 8'h59); tick();
    set_time(8'h00, 8'h00, 8'h00); tick();
    check_eq("ring before rst", RINGING, 1);
    press(2);
    secs(5);
    RST = 1'b1; tick(); RST = 1'b0;
    check_reset_state("mid-snooze rst");

    // Snooze limit behaviour at 06:00
    press(3);
    set_time(8'h05, 8'h59, 8'h59); tick();
    set_time(8'h06, 8'h00, 8'h00); tick();
    check_eq("ring 06:00", RINGING, 1);
    for (int n = 0; n < 3; n++) begin
      press(2);
      check_eq("snooze n", RINGING, 0);
      secs(300);
      check_eq("re-ring n", RINGING, 1);
    end
    press(2);
    check_eq("fourth snz", RINGING, 0);
    secs(300);
`ifdef ALM_SNOOZE_LIMIT_EN
    check_eq("fourth snz stops", RINGING, 0);
`else
    check_eq("fourth snz snoozes", RINGING, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Alarm scheduler for the 24-hour clock datapath. It holds a user-set alarm time in BCD and compares it against the live hour, minute and second counters. It sequences the ring, snooze and stop behaviour and drives the beeper plus the alarm-time display blink enables. It sits beside the time-adjust state machine. The top level routes debounced button pulses to it while alarm mode is selected.

Parameters:
RING_SEC, 60, seconds of ringing before auto-stop (1..511)
SNOOZE_SEC, 300, seconds of silence after a snooze before re-ring (1..511)
MAX_SNOOZE, 3, snooze count limit; used only with ALM_SNOOZE_LIMIT_EN

Ports:
CLK  in  1  system clock (50 MHz domain)
RST  in  1  synchronous, active-high reset
EN1HZ  in  1  one-cycle pulse per second
SIG2HZ  in  1  2 Hz square wave, used for blink and beep gating
HOURH  in  2  live hour tens (BCD)
HOURL  in  4  live hour units
MINH  in  3  live minute tens
MINL  in  4  live minute units
SECH  in  3  live second tens
SECL  in  4  live second units
SET  in  1  pulse; steps through the alarm-setting fields
ADJ  in  1  pulse; increments the field being set, or stops ringing
SNZ  in  1  pulse; snooze
ONOFF  in  1  pulse; toggles alarm enable
AHOURH  out  2  alarm hour tens
AHOURL  out  4  alarm hour units
AMINH  out  3  alarm minute tens
AMINL  out  4  alarm minute units
AHOURON  out  1  hour digit display enable (blinks while that field is set)
AMINON  out  1  minute digit display enable (blinks while that field is set)
ALMEN  out  1  alarm armed
SETTING  out  1  setting FSM not in NORMAL
RINGING  out  1  ring FSM in RING
BEEP  out  1  beeper drive

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high. All state is registered.
- Reset values: alarm = 06:00, ALMEN=0, setting FSM = NORMAL, ring FSM = WAIT, counters = 0, BEEP=0, RINGING=0, SETTING=0, AHOURON=AMINON=1.
- Setting FSM: NORMAL -SET-> S_HOUR -SET-> S_MIN -SET-> NORMAL.
  - ADJ in S_HOUR: hour += 1 in BCD, 23 wraps to 00.
  - ADJ in S_MIN: minute += 1 in BCD, 59 wraps to 00, no carry into hour.
  - Field digit enable = SIG2HZ while that field is being set, otherwise 1.
- Match detection: MATCH = (HOURH:HOURL == alarm hour) && (MINH:MINL == alarm minute) && SECH==0 && SECL==0.
  - MATCH is registered into MATCH_d.
  - TRIG = MATCH & ~MATCH_d & ALMEN & (setting FSM == NORMAL).
- Ring FSM:
  - WAIT -TRIG-> RING, entered the cycle after the rising edge of MATCH. The second counter loads RING_SEC.
  - RING: the counter decrements on EN1HZ.
    - Counter reaches 0 -> WAIT.
    - ADJ -> WAIT (stop).
    - SNZ -> SNOOZE; the counter loads SNOOZE_SEC.
  - SNOOZE: the counter decrements on EN1HZ. Counter reaches 0 -> RING, counter reloads RING_SEC.
  - In RING or SNOOZE, ADJ or SET -> WAIT. That SET pulse is consumed and does not enter S_HOUR.
  - In RING, the ADJ pulse does not modify the alarm time.
- Priority within one cycle: RST > ONOFF-disable > stop (ADJ or SET) > SNZ > counter expiry.
- ONOFF toggles ALMEN. Clearing ALMEN forces the ring FSM to WAIT in the same cycle.
- Edge-only trigger: stopping during the matching second cannot retrigger. MATCH in SNOOZE or RING is ignored. Editing the alarm to equal the current time while in S_MIN does not trigger on return to NORMAL unless a fresh rising edge of MATCH occurs.
- Outputs:
  - BEEP is registered: BEEP <= (ring FSM == RING) & SIG2HZ. One-cycle latency.
  - RINGING and SETTING are decoded from registered state.

Optional Feature:
- Macro: ALM_SNOOZE_LIMIT_EN.
- Defined: a snooze counter increments on each RING->SNOOZE transition and clears on entry to WAIT. SNZ arriving when the count == MAX_SNOOZE acts as a stop (-> WAIT).
- Not defined: snooze is unlimited and no snooze counter exists.

Decomposition:
- Shared package holds:
  - ring state encoding: WAIT, RING, SNOOZE
  - setting state encoding: NORMAL, S_HOUR, S_MIN
  - BCD limits: 23, 59
  - reset alarm time 06:00
- Sub-module alm_bcd_inc performs BCD increment with a selectable wrap limit. It is instantiated for hour and for minute.

Test Plan:
- Reset, then SET, ADJ ×3, SET, ADJ ×2, SET -> alarm 09:02, SETTING=0; AHOURON toggles with SIG2HZ while in S_HOUR.
- ALMEN=1, alarm 09:02, live time moves 09:01:59 -> 09:02:00 -> RINGING=1 on the following cycle; BEEP follows SIG2HZ; after 60 EN1HZ pulses RINGING=0.
- Ringing, SNZ -> RINGING=0 for 300 EN1HZ pulses, then RINGING=1 again; ADJ -> WAIT; no retrigger until the next day's 09:02:00.
- Hour wrap: alarm 23:59, ADJ in S_HOUR -> 00:59; ADJ in S_MIN -> 00:00.
- Same cycle ONOFF and SNZ while ringing -> ALMEN=0, ring FSM in WAIT, BEEP=0 next cycle; RST mid-SNOOZE -> all reset values.
- With ALM_SNOOZE_LIMIT_EN and MAX_SNOOZE=3: the fourth SNZ stops the alarm (WAIT); without the macro, the fourth SNZ enters SNOOZE.
